// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch pipeline.
package if_pkg;

   typedef enum logic [1:0] {
      LOOKUP = 2'd0,
      REQ    = 2'd1,
      FILL   = 2'd2,
      DRAIN  = 2'd3
   } ic_state_e;

   typedef struct packed {
      logic [31:0] vpc;
      logic [3:0]  excp_code;
      logic        excp_vld;
      logic        btb_index;
      logic [1:0]  btb_btype;
      logic [1:0]  btb_bm_pred;
      logic [31:0] btb_target;
      logic        btb_vld;
      logic        btb_way;
   } fetch_pkt_t;

   localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;
   localparam fetch_pkt_t  PKT_ZERO   = '0;

endpackage

// File: rtl/ic_line_store.sv
// Direct-mapped line storage: tag/valid flops plus word-addressed data array.
module ic_line_store #(
   parameter int unsigned LINES = 64,
   parameter int unsigned WORDS = 4,
   parameter int unsigned TAGW  = 22,
   parameter int unsigned IW    = $clog2(LINES),
   parameter int unsigned WB    = $clog2(WORDS)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [IW-1:0]   rd_idx_i,
   input  logic [WB-1:0]   rd_word_i,
   output logic            rd_valid_o,
   output logic [TAGW-1:0] rd_tag_o,
   output logic [31:0]     rd_data_o,
   input  logic            wr_en_i,
   input  logic [IW-1:0]   wr_idx_i,
   input  logic [WB-1:0]   wr_word_i,
   input  logic [31:0]     wr_data_i,
   input  logic            set_en_i,
   input  logic [IW-1:0]   set_idx_i,
   input  logic [TAGW-1:0] set_tag_i,
   input  logic            clr_en_i,
   input  logic [IW-1:0]   clr_idx_i,
   input  logic            clr_all_i
);

   logic [LINES-1:0] valid_q;
   logic [TAGW-1:0]  tag_q  [LINES];
   logic [31:0]      data_q [LINES*WORDS];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[{rd_idx_i, rd_word_i}];

   // Clear-all wins over any per-line update in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < int'(LINES); i++) tag_q[i] <= '0;
      end else if (clr_all_i) begin
         valid_q <= '0;
      end else begin
         if (clr_en_i) valid_q[clr_idx_i] <= 1'b0;
         if (set_en_i) begin
            valid_q[set_idx_i] <= 1'b1;
            tag_q[set_idx_i]   <= set_tag_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) data_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
   end

endmodule

// File: rtl/if3_icache.sv
// Fetch stage 3: direct-mapped I-cache lookup by physical PC with beat-based line refill.
module if3_icache
   import if_pkg::*;
#(
   parameter int unsigned LINES = 64,
   parameter int unsigned WORDS = 4
) (
   input  logic        cpu_clock_i,
   input  logic        cpu_reset_n_i,
   input  logic        flush_i,
   input  logic        inv_i,
   input  logic        if2_valid_i,
   input  logic [31:0] if2_ppc_i,
   input  logic [31:0] if2_vpc_i,
   input  logic [3:0]  if2_excp_code_i,
   input  logic        if2_excp_vld_i,
   input  logic        btb_index_i,
   input  logic [1:0]  btb_btype_i,
   input  logic [1:0]  btb_bm_pred_i,
   input  logic [31:0] btb_target_i,
   input  logic        btb_vld_i,
   input  logic        btb_way_i,
   output logic        busy_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_rlast_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] vpc_o,
   output logic [3:0]  excp_code_o,
   output logic        excp_vld_o,
   output logic        btb_index_o,
   output logic [1:0]  btb_btype_o,
   output logic [1:0]  btb_bm_pred_o,
   output logic [31:0] btb_target_o,
   output logic        btb_vld_o,
   output logic        btb_way_o,
   input  logic        busy_i
);

   localparam int unsigned WB   = $clog2(WORDS);
   localparam int unsigned IW   = $clog2(LINES);
   localparam int unsigned OFF  = 2 + WB;
   localparam int unsigned TAGW = 32 - OFF - IW;

   ic_state_e       state_q;
   logic [WB-1:0]   cnt_q;
   logic            poison_q;
   logic            req_q;
   logic [31:0]     addr_q;
   logic            valid_q;
   logic [31:0]     instr_q;
   fetch_pkt_t      pkt_q;

   logic            rd_valid;
   logic [TAGW-1:0] rd_tag;
   logic [31:0]     rd_data;
   logic            hit_c, lookup_ok_c, accept_c, miss_c;
   logic            wr_en_c, set_en_c;
   fetch_pkt_t      pkt_in_c;
   logic            unused_ppc_lsb;

   assign unused_ppc_lsb = ^if2_ppc_i[1:0];

   always_comb begin
      hit_c       = rd_valid && (rd_tag == if2_ppc_i[31:OFF+IW]);
      lookup_ok_c = hit_c || if2_excp_vld_i;
      accept_c    = (state_q == LOOKUP) && if2_valid_i && lookup_ok_c && !busy_i && !flush_i;
      miss_c      = (state_q == LOOKUP) && if2_valid_i && !lookup_ok_c && !flush_i;
      wr_en_c     = (state_q == FILL) && mem_rvalid_i;
      // A line refilled across an invalidate must stay invalid.
      set_en_c    = wr_en_c && mem_rlast_i && !poison_q && !inv_i;
      pkt_in_c    = '{vpc: if2_vpc_i, excp_code: if2_excp_code_i, excp_vld: if2_excp_vld_i,
                      btb_index: btb_index_i, btb_btype: btb_btype_i, btb_bm_pred: btb_bm_pred_i,
                      btb_target: btb_target_i, btb_vld: btb_vld_i, btb_way: btb_way_i};
   end

   assign busy_o = if2_valid_i && (busy_i || (state_q != LOOKUP) || !lookup_ok_c);

   ic_line_store #(.LINES(LINES), .WORDS(WORDS), .TAGW(TAGW)) u_store (
      .clk_i      (cpu_clock_i),
      .rst_ni     (cpu_reset_n_i),
      .rd_idx_i   (if2_ppc_i[OFF+IW-1:OFF]),
      .rd_word_i  (if2_ppc_i[OFF-1:2]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en_c),
      .wr_idx_i   (addr_q[OFF+IW-1:OFF]),
      .wr_word_i  (cnt_q),
      .wr_data_i  (mem_rdata_i),
      .set_en_i   (set_en_c),
      .set_idx_i  (addr_q[OFF+IW-1:OFF]),
      .set_tag_i  (addr_q[31:OFF+IW]),
      .clr_en_i   (miss_c),
      .clr_idx_i  (if2_ppc_i[OFF+IW-1:OFF]),
      .clr_all_i  (inv_i)
   );

   // Refill controller: beat counter, poison flag and memory request.
   always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
      if (!cpu_reset_n_i) begin
         state_q  <= LOOKUP;
         cnt_q    <= '0;
         poison_q <= 1'b0;
         req_q    <= 1'b0;
         addr_q   <= 32'h0;
      end else begin
         if (inv_i && (state_q == REQ || state_q == FILL)) poison_q <= 1'b1;
         case (state_q)
            LOOKUP: begin
               if (miss_c) begin
                  state_q  <= REQ;
                  req_q    <= 1'b1;
                  addr_q   <= {if2_ppc_i[31:OFF], OFF'(0)};
                  poison_q <= 1'b0;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  req_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= flush_i ? DRAIN : FILL;
               end else if (flush_i) begin
                  req_q   <= 1'b0;
                  state_q <= LOOKUP;
               end
            end
            FILL: begin
               if (mem_rvalid_i) cnt_q <= cnt_q + WB'(1);
               if (mem_rvalid_i && mem_rlast_i) state_q <= LOOKUP;
               else if (flush_i)                state_q <= DRAIN;
            end
            DRAIN: begin
               if (mem_rvalid_i) cnt_q <= cnt_q + WB'(1);
               if (mem_rvalid_i && mem_rlast_i) state_q <= LOOKUP;
            end
            default: state_q <= LOOKUP;
         endcase
      end
   end

   // Decode-side output register; flush kills the packet, decode stall holds it.
   always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
      if (!cpu_reset_n_i) begin
         valid_q <= 1'b0;
         instr_q <= INSTR_ZERO;
         pkt_q   <= PKT_ZERO;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept_c) begin
         valid_q <= 1'b1;
         instr_q <= if2_excp_vld_i ? INSTR_ZERO : rd_data;
         pkt_q   <= pkt_in_c;
      end else if (!busy_i) begin
         valid_q <= 1'b0;
      end
   end

   assign mem_req_o     = req_q;
   assign mem_addr_o    = addr_q;
   assign valid_o       = valid_q;
   assign instr_o       = instr_q;
   assign vpc_o         = pkt_q.vpc;
   assign excp_code_o   = pkt_q.excp_code;
   assign excp_vld_o    = pkt_q.excp_vld;
   assign btb_index_o   = pkt_q.btb_index;
   assign btb_btype_o   = pkt_q.btb_btype;
   assign btb_bm_pred_o = pkt_q.btb_bm_pred;
   assign btb_target_o  = pkt_q.btb_target;
   assign btb_vld_o     = pkt_q.btb_vld;
   assign btb_way_o     = pkt_q.btb_way;

   a_rvalid_in_refill: assert property (@(posedge cpu_clock_i) disable iff (!cpu_reset_n_i)
      mem_rvalid_i |-> (state_q == FILL || state_q == DRAIN));
   a_rlast_full_line: assert property (@(posedge cpu_clock_i) disable iff (!cpu_reset_n_i)
      (mem_rvalid_i && mem_rlast_i && (state_q == FILL || state_q == DRAIN)) |-> (cnt_q == WB'(WORDS-1)));

endmodule
